// File: rtl/pconv_c6_sched.sv
`default_nettype none
// ============================================================================
// Module   : pconv_c6_sched
// Purpose  : Issue/result sequencer for the 6-lane partial-convolution datapath.
// Revision : 1.0 - initial release
// ============================================================================
module pconv_c6_sched #(
    parameter int N       = 16,
    parameter int OUT_CH  = 16,
    parameter int NUM_PIX = 784,
    parameter int PIX_W   = 10,
    parameter int OC_W    = 4,
    parameter int OUT_AW  = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              issue_en,
    output logic              busy,
    output logic              done,
    output logic [PIX_W-1:0]  feat_addr,
    output logic [OC_W-1:0]   wgt_addr,
    output logic              pc_input_vld,
    input  logic              pc_dout_vld,
    output logic [OC_W-1:0]   param_sel,
    output logic              out_we,
    output logic [OUT_AW-1:0] out_addr
);

    localparam int                CNT_W    = PIX_W + OC_W + 1;
    localparam logic [PIX_W-1:0]  LAST_PIX = PIX_W'(NUM_PIX - 1);
    localparam logic [OC_W-1:0]   LAST_OC  = OC_W'(OUT_CH - 1);
    localparam logic [OUT_AW-1:0] OC_MUL   = OUT_AW'(OUT_CH);

    generate
        if (N < 1 || OUT_CH < 1 || NUM_PIX < 1 || (2 ** PIX_W) < NUM_PIX ||
            (2 ** OC_W) < OUT_CH || (2 ** OUT_AW) < NUM_PIX * OUT_CH) begin : g_param_err
            $error("pconv_c6_sched: illegal parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [PIX_W-1:0] ip_q;
    logic [OC_W-1:0]  ic_q;
    logic [PIX_W-1:0] rp_q;
    logic [OC_W-1:0]  rc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             busy_q;
    logic             done_q;
    logic             vld_q;

    logic active;
    logic issue_fire;
    logic recv_fire;
    logic issue_last;
    logic recv_last;

    assign active     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign issue_fire = (state_q == S_ISSUE) && issue_en;
    // A result with nothing outstanding is a protocol violation and is dropped.
    assign recv_fire  = active && pc_dout_vld && (cnt_q != '0);
    assign issue_last = (ic_q == LAST_OC) && (ip_q == LAST_PIX);
    assign recv_last  = (rc_q == LAST_OC) && (rp_q == LAST_PIX);

    always_comb begin
        cnt_d = cnt_q;
        if (issue_fire && !recv_fire) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!issue_fire && recv_fire) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ip_q    <= '0;
            ic_q    <= '0;
            rp_q    <= '0;
            rc_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            vld_q  <= issue_fire;
            cnt_q  <= cnt_d;

            // Channel inner, pixel outer; both wrap to 0 after the final op.
            if (issue_fire) begin
                if (ic_q == LAST_OC) begin
                    ic_q <= '0;
                    ip_q <= (ip_q == LAST_PIX) ? '0 : ip_q + 1'b1;
                end else begin
                    ic_q <= ic_q + 1'b1;
                end
            end

            if (recv_fire) begin
                if (rc_q == LAST_OC) begin
                    rc_q <= '0;
                    rp_q <= (rp_q == LAST_PIX) ? '0 : rp_q + 1'b1;
                end else begin
                    rc_q <= rc_q + 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_ISSUE;
                        busy_q  <= 1'b1;
                        ip_q    <= '0;
                        ic_q    <= '0;
                        rp_q    <= '0;
                        rc_q    <= '0;
                        cnt_q   <= '0;
                    end
                end
                S_ISSUE: begin
                    if (issue_fire && issue_last) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (recv_fire && recv_last) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign pc_input_vld = vld_q;
    assign feat_addr    = ip_q;
    assign wgt_addr     = ic_q;
    assign param_sel    = rc_q;
    assign out_we       = recv_fire;
    assign out_addr     = OUT_AW'(rp_q) * OC_MUL + OUT_AW'(rc_q);

endmodule
`default_nettype wire

// File: tb/tb_pconv_c6_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_pconv_c6_sched
// Purpose  : Self-checking bench for pconv_c6_sched with memory/datapath models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pconv_c6_sched;

    localparam int OC    = 2;
    localparam int NP    = 3;
    localparam int PW    = 2;
    localparam int OW    = 1;
    localparam int OA    = 3;
    localparam int TOTAL = OC * NP;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          issue_en;
    logic          busy;
    logic          done;
    logic [PW-1:0] feat_addr;
    logic [OW-1:0] wgt_addr;
    logic          pc_input_vld;
    logic          pc_dout_vld;
    logic [OW-1:0] param_sel;
    logic          out_we;
    logic [OA-1:0] out_addr;

    pconv_c6_sched #(
        .N       (16),
        .OUT_CH  (OC),
        .NUM_PIX (NP),
        .PIX_W   (PW),
        .OC_W    (OW),
        .OUT_AW  (OA)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .issue_en     (issue_en),
        .busy         (busy),
        .done         (done),
        .feat_addr    (feat_addr),
        .wgt_addr     (wgt_addr),
        .pc_input_vld (pc_input_vld),
        .pc_dout_vld  (pc_dout_vld),
        .param_sel    (param_sel),
        .out_we       (out_we),
        .out_addr     (out_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        int sum;
    } pe_t;

    int  feat [NP][6];
    int  wgt  [OC][6];
    int  bias [OC];
    int  shft [OC];
    pe_t pipe [$];
    int  wr_vals [$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 3;
    int last_fa  = 0;
    int last_wa  = 0;
    int n_writes = 0;
    int n_done   = 0;

    // Spec-level layer model: ops issued, results written, flag pulses.
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_vld  = 1'b0;
    int m_issued  = 0;
    int m_written = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int dot(input int p, input int c);
        int s;
        if (p < 0 || p >= NP || c < 0 || c >= OC) return -99999;
        s = 0;
        for (int l = 0; l < 6; l++) s += feat[p][l] * wgt[c][l];
        return s;
    endfunction

    function automatic int dp_out(input int s, input int b, input int sh);
        int v;
        v = (s + b) >>> sh;
        if (v < 0) v = 0;
        if (v > 127) v = 127;
        return v;
    endfunction

    function automatic int ref_val(input int k);
        return dp_out(dot(k / OC, k % OC), bias[k % OC], shft[k % OC]);
    endfunction

    // One clock cycle: drive inputs, model memories/datapath, check, advance.
    task automatic step(input bit st, input bit ie, input bit spur);
        bit  exp_we;
        bit  popped;
        bit  nb;
        bit  nd;
        bit  nv;
        int  psum;
        int  sel;
        int  dpv;
        pe_t e;
        start    = st;
        issue_en = ie;
        if (pc_input_vld === 1'b1) begin
            e.due = cyc + lat;
            e.sum = dot(last_fa, last_wa);
            pipe.push_back(e);
        end
        popped = 1'b0;
        psum   = 0;
        if (pipe.size() > 0 && pipe[0].due == cyc) begin
            psum = pipe[0].sum;
            void'(pipe.pop_front());
            popped = 1'b1;
        end
        pc_dout_vld = spur | popped;
        #1;
        exp_we = pc_dout_vld && m_busy && (m_issued > m_written);
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("pc_input_vld", 32'(pc_input_vld), 32'(m_vld));
        if (m_busy && m_issued < TOTAL) begin
            chk("feat_addr", 32'(feat_addr), m_issued / OC);
            chk("wgt_addr", 32'(wgt_addr), m_issued % OC);
        end
        chk("out_we", 32'(out_we), 32'(exp_we));
        if (exp_we && out_we === 1'b1) begin
            chk("out_addr", 32'(out_addr), m_written);
            chk("param_sel", 32'(param_sel), m_written % OC);
            sel = int'(param_sel);
            dpv = dp_out(psum, bias[sel], shft[sel]);
            chk("wdata", dpv, ref_val(m_written));
            wr_vals.push_back(dpv);
            n_writes++;
        end
        if (done === 1'b1) n_done++;
        last_fa = int'(feat_addr);
        last_wa = int'(wgt_addr);

        if (rst_n !== 1'b1) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_vld  = 1'b0;
        end else begin
            nb = m_busy;
            nd = 1'b0;
            nv = 1'b0;
            if (m_busy) begin
                if (m_issued < TOTAL && ie) begin
                    nv = 1'b1;
                    m_issued++;
                end
                if (exp_we) begin
                    m_written++;
                    if (m_written == TOTAL) begin
                        nd = 1'b1;
                        nb = 1'b0;
                    end
                end
            end else if (!m_done && st) begin
                nb = 1'b1;
                m_issued  = 0;
                m_written = 0;
            end
            m_busy = nb;
            m_done = nd;
            m_vld  = nv;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One full layer; cycle numbers are relative to the start cycle (0).
    task automatic run_layer(input int gap_from, input int gap_to, input bit rnd, input bit junk);
        int w0;
        int d0;
        bit ie;
        bit st;
        w0 = n_writes;
        d0 = n_done;
        step(1'b1, 1'b1, 1'b0);
        for (int c = 1; c < 300 && (m_busy || m_done); c++) begin
            ie = rnd ? ($urandom_range(0, 3) != 0) : !(c >= gap_from && c <= gap_to);
            st = junk && (m_done || c == 3);
            step(st, ie, 1'b0);
        end
        chk("layer_end", 32'(m_busy | m_done), 0);
        chk("writes", n_writes - w0, TOTAL);
        chk("done_pulses", n_done - d0, 1);
    endtask

    task automatic randomize_tables();
        for (int p = 0; p < NP; p++)
            for (int l = 0; l < 6; l++) feat[p][l] = int'($urandom_range(0, 15));
        for (int c = 0; c < OC; c++) begin
            for (int l = 0; l < 6; l++) wgt[c][l] = int'($urandom_range(0, 15)) - 4;
            bias[c] = int'($urandom_range(0, 600)) - 300;
            shft[c] = int'($urandom_range(0, 3));
        end
    endtask

    initial begin
        int oa0;
        int ps0;
        rst_n       = 1'b0;
        start       = 1'b0;
        issue_en    = 1'b0;
        pc_dout_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_vld", 32'(pc_input_vld), 0);
        chk("rst_we", 32'(out_we), 0);
        chk("rst_feat_addr", 32'(feat_addr), 0);
        chk("rst_wgt_addr", 32'(wgt_addr), 0);
        chk("rst_out_addr", 32'(out_addr), 0);

        // Bias alignment: every dot product is 100, bias {0,256}, shift 1.
        for (int p = 0; p < NP; p++)
            for (int l = 0; l < 6; l++) feat[p][l] = (l == 0) ? 10 : 0;
        for (int c = 0; c < OC; c++)
            for (int l = 0; l < 6; l++) wgt[c][l] = (l == 0) ? 10 : 0;
        bias[0] = 0;
        bias[1] = 256;
        shft[0] = 1;
        shft[1] = 1;
        wr_vals.delete();
        run_layer(0, -1, 1'b0, 1'b0);
        if (wr_vals.size() >= 2) begin
            chk("bias0_value", wr_vals[0], 50);
            chk("bias1_clamped", wr_vals[1], 127);
        end else begin
            chk("value_count", wr_vals.size(), TOTAL);
        end

        randomize_tables();
        run_layer(3, 4, 1'b0, 1'b0);
        run_layer(0, -1, 1'b0, 1'b1);

        // Reset two cycles after the third issue, then a clean layer.
        step(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 20 && m_issued < 3; c++) step(1'b0, 1'b1, 1'b0);
        chk("third_issue_reached", m_issued, 3);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        chk("busy_after_reset", 32'(busy), 0);
        for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 1'b0);
        chk("inflight_drained", pipe.size(), 0);
        run_layer(0, -1, 1'b0, 1'b0);

        // Spurious datapath strobes while idle.
        oa0 = int'(out_addr);
        ps0 = int'(param_sel);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("spur_out_addr", 32'(out_addr), oa0);
        chk("spur_param_sel", 32'(param_sel), ps0);
        run_layer(0, -1, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            randomize_tables();
            lat = int'($urandom_range(1, 5));
            run_layer(0, -1, 1'b1, r[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pconv_c6_sched.md
Name: pconv_c6_sched

Overview:
- Sequencer for one 6-lane partial-convolution datapath: 6 channels × 6 weights, summed, then bias, shift, ReLU and clamp.
- Walks every output pixel × output channel of a layer with 6 input channels.
- Issues feature/weight memory reads, times the datapath's input_vld, selects the bias/shift entry for the result in flight, and writes results to the output feature buffer.
- Sits between the layer controller (start/done) and the datapath, feature memory, weight memory and output buffer.

Parameters:
- N, 16, datapath element width.
- OUT_CH, 16, output channels per pixel; ≥1.
- NUM_PIX, 784, output pixels per layer; ≥1.
- PIX_W, 10, pixel-counter/feature-address width; 2^PIX_W ≥ NUM_PIX.
- OC_W, 4, channel-counter/weight-address width; 2^OC_W ≥ OUT_CH.
- OUT_AW, 14, output-address width; 2^OUT_AW ≥ NUM_PIX*OUT_CH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Synchronous, active-low.
- start  in  1  one-cycle pulse; starts a layer when idle.
- issue_en  in  1  issue permission; low freezes new issues only.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse when the last result is written.
- feat_addr  out  PIX_W  feature-memory read address, 1-cycle read latency.
- wgt_addr  out  OC_W  weight-memory read address, 1-cycle read latency.
- pc_input_vld  out  1  datapath input_vld; aligned with memory read data.
- pc_dout_vld  in  1  datapath conv_dout_vld; one high cycle per result.
- param_sel  out  OC_W  bias/shift table index; combinational table feeds the datapath bias_din/shift_din.
- out_we  out  1  output-buffer write strobe.
- out_addr  out  OUT_AW  output-buffer write address.

Behaviour:
- Reset: state IDLE; all counters 0; busy, done, pc_input_vld, out_we 0; addresses 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 → ISSUE, busy=1 next cycle; issue pixel ip=0, issue channel ic=0, result pixel rp=0, result channel rc=0.
  - start while busy is ignored.
- ISSUE:
  - Each cycle with issue_en=1 issues one op: feat_addr=ip, wgt_addr=ic.
  - Loop order: channel inner, pixel outer. ic wraps OUT_CH-1→0 and increments ip.
  - Issue flag is registered → pc_input_vld=1 exactly 1 cycle after the address cycle.
  - issue_en=0: no issue; addresses hold; pc_input_vld=0 the following cycle.
  - After issuing ip=NUM_PIX-1, ic=OUT_CH-1 → DRAIN.
- Result side runs in ISSUE and DRAIN, in parallel with issuing:
  - Results return in issue order.
  - Each pc_dout_vld=1 cycle: out_we=1, out_addr=rp*OUT_CH+rc, combinational in the same cycle.
  - Then rc/rp advance with the same wrap rule as ic/ip.
  - param_sel=rc at all times, so bias/shift match the result on the datapath output.
- DRAIN:
  - No issues.
  - When the result for rp=NUM_PIX-1, rc=OUT_CH-1 is written → DONE.
- DONE: done=1 for one cycle; busy=0 in the same cycle; → IDLE.
- Outstanding count = issued − received, width PIX_W+OC_W+1.
  - pc_dout_vld while count=0 is a protocol error: ignored, no write.
  - Issue and receive in the same cycle leave the count unchanged.
- out_addr arithmetic is unsigned; the product is truncated to OUT_AW bits (fits by parameter rule).
- OUT_CH=1: ic stays 0 and ip increments every issue.
- NUM_PIX=1: ISSUE lasts exactly OUT_CH issuing cycles.
- Reset mid-layer: everything returns to IDLE next edge; in-flight results after reset are ignored; no done.
- start in the DONE cycle is ignored.

Test Plan:
- OUT_CH=2, NUM_PIX=3, issue_en=1, datapath model with 3-cycle latency, start at cycle 0:
  - (feat_addr, wgt_addr) sequence (0,0),(0,1),(1,0),(1,1),(2,0),(2,1) on cycles 1–6.
  - pc_input_vld high cycles 2–7.
  - out_addr 0..5 in order; done one cycle after the 6th write.
- Same configuration, issue_en low on cycles 3–4:
  - Addresses hold for those cycles; pc_input_vld gaps on cycles 4–5.
  - All 6 writes still occur; out_addr 0..5, no duplicates or skips.
- Bias alignment: when pc_dout_vld and rc=1, param_sel=1.
  - With table {bias0=0, bias1=256, shift=1} and products summing to 100: written values 50 and 127 (clamped).
- start pulsed mid-layer and again in the DONE cycle: both ignored; exactly one done pulse; 6 writes.
- rst_n low 2 cycles after the 3rd issue:
  - busy=0 next edge; late pc_dout_vld produces no out_we.
  - A fresh start then completes with the full 0..5 write sequence.
- Spurious pc_dout_vld while IDLE: no out_we, counters unchanged.
